// File: rtl/serial_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the serial device.
// Latency: req seen at posedge N -> dev_enable cycle N..N+1, ack cycle N+1..N+2.
// Backpressure: requests wait through ACCESS/RESP; one access per 3 cycles. Optional lock: SERIAL_ARB_LOCK_EN.
module serial_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              _reset,
   input  logic [1:0]        req,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [1:0]        lock,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        grant,
   output logic              dev_enable,
   output logic              dev_rw,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [DATA_W-1:0] dev_wdata,
   input  logic [DATA_W-1:0] dev_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t     state, state_nxt;
   logic [1:0] req_eff;
   logic       sel_idx;
   logic       win_idx;
   logic       last_served;

`ifdef SERIAL_ARB_LOCK_EN
   logic owner_vld;
   logic owner_idx;

   // While a port owns the lock, only its request is visible to arbitration.
   always_comb begin
      req_eff = req;
      if (owner_vld)
         req_eff = owner_idx ? (req & 2'b10) : (req & 2'b01);
   end

   // Lock ownership follows the lock bit sampled as each access completes.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         owner_vld <= 1'b0;
         owner_idx <= 1'b0;
      end else if (state == ACCESS) begin
         owner_vld <= lock[win_idx];
         owner_idx <= win_idx;
      end
   end
`else
   logic [1:0] unused_lock;

   // Lock inputs are present for port compatibility but have no effect.
   always_comb begin
      req_eff     = req;
      unused_lock = lock;
   end
`endif

   // Winner select: a lone requester wins, contention goes to the port not served last.
   always_comb begin
      sel_idx = 1'b0;
      case (req_eff)
         2'b01:   sel_idx = 1'b0;
         2'b10:   sel_idx = 1'b1;
         default: sel_idx = ~last_served;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and state-decoded strobes.
   always_comb begin
      state_nxt  = state;
      dev_enable = 1'b0;
      ack        = 2'b00;
      case (state)
         IDLE:   if (req_eff != 2'b00) state_nxt = ACCESS;
         ACCESS: begin
            dev_enable = 1'b1;
            state_nxt  = RESP;
         end
         RESP:   begin
            ack       = grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the winner's request, return read data and track fairness history.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         grant       <= 2'b00;
         win_idx     <= 1'b0;
         last_served <= 1'b1;
         dev_rw      <= 1'b0;
         dev_addr    <= '0;
         dev_wdata   <= '0;
         rdata       <= '0;
      end else begin
         case (state)
            IDLE: if (req_eff != 2'b00) begin
               win_idx   <= sel_idx;
               grant     <= sel_idx ? 2'b10 : 2'b01;
               dev_rw    <= sel_idx ? rw1 : rw0;
               dev_addr  <= sel_idx ? addr1 : addr0;
               dev_wdata <= sel_idx ? wdata1 : wdata0;
            end
            ACCESS: begin
               if (!dev_rw) rdata <= dev_rdata;
               last_served <= win_idx;
            end
            RESP: grant <= 2'b00;
            default: grant <= 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_arbiter.sv
module tb_serial_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic        rw0, rw1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  lock;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic [1:0]  grant;
   logic        dev_enable;
   logic        dev_rw;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      ._reset     (rst_n),
      .req        (req),
      .rw0        (rw0),
      .rw1        (rw1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .lock       (lock),
      .ack        (ack),
      .rdata      (rdata),
      .grant      (grant),
      .dev_enable (dev_enable),
      .dev_rw     (dev_rw),
      .dev_addr   (dev_addr),
      .dev_wdata  (dev_wdata),
      .dev_rdata  (dev_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Expected grant order for the lock scenario: port 1 writes 'a','b','c', port 0 one read.
`ifdef SERIAL_ARB_LOCK_EN
   logic [1:0] lock_exp [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
   logic [1:0] lock_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b10};
`endif
   logic [7:0] chars [3] = '{8'h61, 8'h62, 8'h63};

   initial begin
      int ci;
      rst_n = 1'b0; req = 2'b00; rw0 = 1'b0; rw1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      lock = 2'b00; dev_rdata = '0;

      // Reset state
      step(); step();
      check("rst_ack", ack, 2'b00);
      check("rst_grant", grant, 2'b00);
      check("rst_en", dev_enable, 1'b0);
      check("rst_rw", dev_rw, 1'b0);
      check("rst_addr", dev_addr, 32'h0);
      check("rst_wdata", dev_wdata, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      step();

      // Single read on port 0
      req = 2'b01; rw0 = 1'b0; addr0 = 32'h20; dev_rdata = 32'h41;
      step();
      check("rd_en", dev_enable, 1'b1);
      check("rd_addr", dev_addr, 32'h20);
      check("rd_rw", dev_rw, 1'b0);
      check("rd_grant", grant, 2'b01);
      check("rd_noack", ack, 2'b00);
      step();
      check("rd_ack", ack, 2'b01);
      check("rd_data", rdata, 32'h41);
      check("rd_en_off", dev_enable, 1'b0);
      req = 2'b00;
      step();
      check("rd_idle_ack", ack, 2'b00);
      check("rd_idle_grant", grant, 2'b00);
      check("rd_hold", rdata, 32'h41);

      // Single write on port 1; rdata must not pick up device data
      req = 2'b10; rw1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h0A; dev_rdata = 32'h99;
      step();
      check("wr_en", dev_enable, 1'b1);
      check("wr_rw", dev_rw, 1'b1);
      check("wr_wdata", dev_wdata, 32'h0A);
      check("wr_grant", grant, 2'b10);
      step();
      check("wr_ack", ack, 2'b10);
      check("wr_rdata", rdata, 32'h41);
      req = 2'b00;
      step();

      // Contention from reset: alternate 01,10,01,10 with acks 3 cycles apart
      rst_n = 1'b0; step(); rst_n = 1'b1;
      req = 2'b11; rw0 = 1'b0; addr0 = 32'h30; rw1 = 1'b1; addr1 = 32'h31; dev_rdata = 32'h77;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("ct_grant%0d", i), grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("ct_addr%0d", i), dev_addr, (i % 2 == 0) ? 32'h30 : 32'h31);
         step();
         check($sformatf("ct_ack%0d", i), ack, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
         check($sformatf("ct_gap%0d", i), ack, 2'b00);
      end
      req = 2'b00;
      step(); step();

      // Request dropped during ACCESS still completes
      req = 2'b01;
      step();
      check("drop_grant", grant, 2'b01);
      req = 2'b00;
      step();
      check("drop_ack", ack, 2'b01);
      step();

      // Reset mid-ACCESS: port 1 wins contention (port 0 served last), then reset
      req = 2'b11; rw0 = 1'b0; addr0 = 32'h40; dev_rdata = 32'h55;
      step();
      check("mid_grant", grant, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("mid_en", dev_enable, 1'b0);
      check("mid_grant0", grant, 2'b00);
      check("mid_ack", ack, 2'b00);
      step();
      check("mid_noack", ack, 2'b00);
      rst_n = 1'b1;
      step();
      check("mid_p0wins", grant, 2'b01);
      step();
      check("mid_ack0", ack, 2'b01);
      check("mid_rdata", rdata, 32'h55);
      req = 2'b00;
      step();

      // Lock scenario: port 0 was served last, so port 1 starts
      ci = 0;
      req = 2'b11; rw0 = 1'b0; addr0 = 32'h20; rw1 = 1'b1; addr1 = 32'h20;
      wdata1 = {24'h0, chars[0]}; lock = 2'b10;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("lk_grant%0d", i), grant, lock_exp[i]);
         if (grant == 2'b10)
            check($sformatf("lk_char%0d", i), dev_wdata, {24'h0, chars[ci]});
         step();
         check($sformatf("lk_ack%0d", i), ack, lock_exp[i]);
         if (ack[1]) begin
            ci++;
            if (ci < 3) wdata1 = {24'h0, chars[ci]};
            if (ci >= 2) lock = 2'b00;
            if (ci >= 3) req[1] = 1'b0;
         end
         if (ack[0]) req[0] = 1'b0;
         step();
      end
      check("lk_done", req, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_arbiter.md
# serial_arbiter

Two-master arbiter and access sequencer for the memory-mapped simulated serial device. Sits between two bus requesters (port 0: CPU data bus, port 1: auxiliary/debug master) and the single serial device port. Grants one access at a time with round-robin fairness, sequences the device enable/rw strobes, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- _reset  in  1  asynchronous, active-low reset
- req  in  2  per-port request; held high, with rw/addr/wdata stable, until ack
- rw0, rw1  in  1  1 = write (putchar), 0 = read (getchar)
- addr0, addr1  in  ADDR_W  request address, passed through undecoded
- wdata0, wdata1  in  DATA_W  write data
- lock  in  2  per-port lock request (used only with SERIAL_ARB_LOCK_EN)
- ack  out  2  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data of last completed read; valid while ack high, held after
- grant  out  2  one-hot current owner, high in ACCESS and RESP
- dev_enable  out  1  device strobe, high for exactly the ACCESS cycle
- dev_rw  out  1  registered copy of winner's rw
- dev_addr  out  ADDR_W  registered copy of winner's addr
- dev_wdata  out  DATA_W  registered copy of winner's wdata
- dev_rdata  in  DATA_W  device read data, valid by the posedge ending ACCESS

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if req != 0 at posedge, select winner, register dev_rw/dev_addr/dev_wdata, set dev_enable=1, set grant, go ACCESS. Else stay.
- Winner: single requester wins outright; if both, the port not in last_served wins. last_served resets to 1, so port 0 wins the first contention.
- ACCESS: device acts on negedge. Next posedge: dev_enable=0; if dev_rw=0, rdata <= dev_rdata (rdata unchanged on writes); ack[winner]=1; last_served <= winner; go RESP.
- RESP: next posedge: ack=0, grant=0, go IDLE. Requester must drop or change req on seeing ack; req still high at the following IDLE is a new request.
- dev_addr/dev_wdata/dev_rw hold their last value outside ACCESS.
- Requests arriving during ACCESS/RESP wait; nothing is dropped.

## Timing
- Request seen at posedge N: dev_enable high cycle N..N+1, ack high cycle N+1..N+2, IDLE from N+2, next arbitration at posedge N+3 earliest.
- Latency req→ack: 2 cycles; throughput: one access per 3 cycles.
- Reset values: ack=0, grant=0, dev_enable=0, dev_rw=0, dev_addr=0, dev_wdata=0, rdata=0, state=IDLE, last_served=1, lock owner none.
- Reset asserted mid-ACCESS: dev_enable drops immediately (async); no ack issued; transaction is lost, requester must reissue.
- req deasserted illegally before ack: transaction still completes and ack is still pulsed.

## Configuration
- SERIAL_ARB_LOCK_EN defined: if lock[winner] is high at the posedge that issues ack, winner becomes lock owner; in IDLE only the owner's req is considered. Ownership ends after the first owned transaction completing with lock low, or at reset. Keeps multi-character strings atomic.
- Not defined: lock ports exist but are ignored; pure round-robin.

## Test plan
- Single read: req=01, rw0=0, addr0=0x20; device returns 0x41 -> dev_enable one cycle with dev_addr=0x20, ack=01 two cycles after request, rdata=0x41.
- Single write: req=10, rw1=1, addr1=0x20, wdata1=0x0A -> dev_rw=1, dev_wdata=0x0A, ack=10, rdata unchanged.
- Contention: req=11 from reset, both held after ack -> grants 01,10,01,10 alternating, each ack 3 cycles apart.
- Reset mid-ACCESS: drop _reset during dev_enable=1 -> dev_enable=0, grant=0 immediately, no ack; after release, port 0 wins next.
- Lock (SERIAL_ARB_LOCK_EN): port 1 holds lock=1 for 3 writes 'a','b','c' while port 0 requests -> three consecutive grant=10, then grant=01; without macro, grants alternate.
